// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM stage: req/ack handshake with address, write data and read data.
// The master side (mem_access_unit) drives the request; the slave side is the memory.
interface mem_access_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage of the 5-stage core: turns EX/MEM load/store into a req/ack memory access, stalls upstream
// until it completes, and doubles as the MEM/WB register. Define MEM_TIMEOUT_EN to abort stuck accesses.
module mem_access_unit #(
    parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
    , parameter int MAX_WAIT = 15
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] Write_Data_i,
    input  logic [4:0]        RD_addr_i,
    mem_access_unit_if.master mem,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALU_result_o,
    output logic [DATA_W-1:0] Read_Data_o,
    output logic [4:0]        RD_addr_o
`ifdef MEM_TIMEOUT_EN
    , output logic            timeout_o
`endif
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_access;
    logic              w_aligned;
    logic              w_start;
    logic              w_done;
    logic              w_stall;
    logic              w_misalign;
    logic              w_capture;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_misalign;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_read_data;
    logic [4:0]        r_rd_addr;

    assign w_access  = MemRead_i | MemWrite_i;
    assign w_aligned = (ALU_result_i[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_abort;
    logic             r_timeout;

    // Abort on the WAIT cycle whose missing ack would bring the count to MAX_WAIT; an ack there still wins.
    assign w_abort = (r_state == S_WAIT) && !mem.mem_ack_i && (r_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_abort;
            if (w_start) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && !mem.mem_ack_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_o = r_timeout;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_stall     = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (w_aligned) begin
                        w_start     = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_misalign  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem.mem_ack_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end
`endif
                else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // MEM/WB takes a real instruction only when it leaves MEM without error; everything else is a bubble.
    assign w_capture = ((r_state == S_IDLE) && !w_access) || w_done;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_start) begin
            r_addr  <= ALU_result_i;
            r_wdata <= Write_Data_i;
            r_we    <= MemWrite_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_misalign   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_alu_result <= '0;
            r_read_data  <= '0;
            r_rd_addr    <= '0;
        end else begin
            r_misalign <= w_misalign;
            if (w_capture) begin
                r_regwrite   <= RegWrite_i;
                r_memtoreg   <= MemtoReg_i;
                r_alu_result <= ALU_result_i;
                r_rd_addr    <= RD_addr_i;
                if (w_done && !r_we) begin
                    r_read_data <= mem.mem_rdata_i;
                end
            end else begin
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
            end
        end
    end

    assign stall_o         = rst_i & w_stall;
    assign mem.mem_req_o   = (r_state == S_WAIT);
    assign mem.mem_we_o    = r_we;
    assign mem.mem_addr_o  = r_addr;
    assign mem.mem_wdata_o = r_wdata;
    assign misalign_o      = r_misalign;
    assign RegWrite_o      = r_regwrite;
    assign MemtoReg_o      = r_memtoreg;
    assign ALU_result_o    = r_alu_result;
    assign Read_Data_o     = r_read_data;
    assign RD_addr_o       = r_rd_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver acting as the upstream pipeline, a memory responder
// with random latency, and a writeback monitor checking MEM/WB against a reference model.
module tb_mem_access_unit;

    localparam int DATA_W = 32;
`ifdef MEM_TIMEOUT_EN
    localparam int MAX_WAIT    = 4;
    localparam int LAT_MAX     = 4;
    localparam int ABORT_STALL = MAX_WAIT;
`else
    localparam int LAT_MAX     = 6;
    localparam int ABORT_STALL = 0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } mem_exp_t;

    typedef struct {
        logic        mis;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mtr;
        logic [31:0] rdata;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALU_result_i, Write_Data_i;
    logic [4:0]  RD_addr_i;
    logic        stall_o, misalign_o, RegWrite_o, MemtoReg_o;
    logic [31:0] ALU_result_o, Read_Data_o;
    logic [4:0]  RD_addr_o;
`ifdef MEM_TIMEOUT_EN
    logic        timeout_o;
`endif

    mem_access_unit_if #(.DATA_W(DATA_W)) mem_bus ();

    mem_access_unit #(
        .DATA_W(DATA_W)
`ifdef MEM_TIMEOUT_EN
        , .MAX_WAIT(MAX_WAIT)
`endif
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .RegWrite_i  (RegWrite_i),
        .MemtoReg_i  (MemtoReg_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .ALU_result_i(ALU_result_i),
        .Write_Data_i(Write_Data_i),
        .RD_addr_i   (RD_addr_i),
        .mem         (mem_bus),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .RegWrite_o  (RegWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .ALU_result_o(ALU_result_o),
        .Read_Data_o (Read_Data_o),
        .RD_addr_o   (RD_addr_o)
`ifdef MEM_TIMEOUT_EN
        , .timeout_o (timeout_o)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    mem_exp_t    mem_q[$];
    wb_exp_t     wb_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference memory: unwritten words read back as a fixed function of their address.
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 32'hC3C3_0F0F;
    endfunction

    // Memory responder: acks the lat-th request cycle, random ack noise and read data otherwise.
    int       rsp_cnt = 0;
    mem_exp_t rsp_cur;
    always @(posedge clk) begin
        #1;
        if (mem_bus.mem_req_o !== 1'b1) begin
            rsp_cnt = 0;
            mem_bus.mem_ack_i   = ($urandom_range(0, 7) == 0);
            mem_bus.mem_rdata_i = $urandom;
        end else begin
            if (rsp_cnt == 0) begin
                if (mem_q.size() == 0) begin
                    check("req_unexpected", 64'(mem_bus.mem_req_o), 64'd0);
                    rsp_cur = '{addr: 0, we: 0, wdata: 0, rdata: 0, lat: 0};
                end else begin
                    rsp_cur = mem_q.pop_front();
                end
            end
            check("req_addr", 64'(mem_bus.mem_addr_o), 64'(rsp_cur.addr));
            check("req_we", 64'(mem_bus.mem_we_o), 64'(rsp_cur.we));
            if (rsp_cur.we) check("req_wdata", 64'(mem_bus.mem_wdata_o), 64'(rsp_cur.wdata));
            rsp_cnt++;
            mem_bus.mem_ack_i   = (rsp_cnt == rsp_cur.lat);
            mem_bus.mem_rdata_i = (rsp_cnt == rsp_cur.lat) ? rsp_cur.rdata : $urandom;
        end
    end

    // Writeback monitor: every writeback or misalign pulse must match the next expected instruction.
    wb_exp_t mon_e;
    always @(negedge clk) begin
        if (rst_i === 1'b1) begin
            if (RegWrite_o || misalign_o) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 64'({RegWrite_o, misalign_o}), 64'd0);
                end else begin
                    mon_e = wb_q.pop_front();
                    check("wb_misalign", 64'(misalign_o), 64'(mon_e.mis));
                    if (mon_e.mis) begin
                        check("wb_bubble_on_misalign", 64'(RegWrite_o), 64'd0);
                    end else begin
                        check("wb_regwrite", 64'(RegWrite_o), 64'd1);
                        check("wb_alu_result", 64'(ALU_result_o), 64'(mon_e.alu));
                        check("wb_rd_addr", 64'(RD_addr_o), 64'(mon_e.rd));
                        check("wb_memtoreg", 64'(MemtoReg_o), 64'(mon_e.mtr));
                        check("wb_read_data", 64'(Read_Data_o), 64'(mon_e.rdata));
                    end
                end
            end else begin
                check("bubble_memtoreg", 64'(MemtoReg_o), 64'd0);
            end
        end
    end

    // Present one instruction, record its expected memory and writeback effects, hold it while stalled.
    // lat is the WAIT cycle carrying the ack (1 = first); lat 0 means the memory never answers.
    task automatic issue(input logic rw, input logic mr, input logic mwr, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, input int lat);
        logic     acc, algn, ld, abort, s;
        int       exp_stall, stalls;
        mem_exp_t me;
        acc   = mr | mwr;
        algn  = (alu[1:0] == 2'b00);
        ld    = mr & ~mwr;
        abort = acc && algn && (lat == 0);
        RegWrite_i   = rw;
        MemtoReg_i   = rw & ld;
        MemRead_i    = mr;
        MemWrite_i   = mwr;
        ALU_result_i = alu;
        Write_Data_i = wd;
        RD_addr_i    = rd;
        exp_stall    = 0;
        if (acc && algn) begin
            me = '{addr: alu, we: mwr, wdata: wd, rdata: ref_read(alu), lat: lat};
            mem_q.push_back(me);
            if (abort) begin
                exp_stall = ABORT_STALL;
            end else begin
                exp_stall = lat;
                if (mwr) ref_mem[alu] = wd;
                else     last_rd = me.rdata;
            end
        end
        if (acc && !algn) wb_q.push_back('{mis: 1'b1, alu: 0, rd: 0, mtr: 0, rdata: 0});
        else if (rw && !abort) wb_q.push_back('{mis: 1'b0, alu: alu, rd: rd, mtr: rw & ld, rdata: last_rd});
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            s = stall_o;
            @(posedge clk);
            #1;
            if (!s) break;
            stalls++;
        end
        check("stall_cycles", 64'(stalls), 64'(exp_stall));
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1);
    endtask

    int          k;
    logic [31:0] a;
    logic        rw, mr, mwr;

    initial begin
        RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        ALU_result_i = 32'h40; Write_Data_i = '0; RD_addr_i = '0;

        // Reset held for two edges with a load pending: nothing may leave the block.
        @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({mem_bus.mem_req_o, stall_o, misalign_o, RegWrite_o, MemtoReg_o}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_2", 64'({mem_bus.mem_req_o, stall_o, misalign_o, RegWrite_o, MemtoReg_o}), 64'd0);
        check("reset_alu_result", 64'(ALU_result_o), 64'd0);
        check("reset_read_data", 64'(Read_Data_o), 64'd0);
        check("reset_rd_addr", 64'(RD_addr_o), 64'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;

        ref_mem[32'h40] = 32'hDEADBEEF;
        issue(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1);
        issue(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7, 3);
        issue(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 1);
        issue(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd9, 1);
        issue(1'b1, 1'b1, 1'b1, 32'h80, 32'h1357_9BDF, 5'd3, 2);
        issue(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd4, 1);
        nop();

        for (int n = 0; n < 300; n++) begin
            k   = $urandom_range(0, 3);
            a   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (k == 0) a = $urandom;
            rw  = (k == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            mr  = (k == 1) || (k == 3);
            mwr = (k == 2) || (k == 3);
            issue(rw, mr, mwr, a, $urandom, 5'($urandom), $urandom_range(1, LAT_MAX));
            if ($urandom_range(0, 3) == 0) nop();
        end

        // Reset while a load waits on a silent memory: the request is dropped at the reset edge.
        RegWrite_i = 1'b1; MemtoReg_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        ALU_result_i = 32'h100; RD_addr_i = 5'd12;
        mem_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 0, rdata: 0, lat: 0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("req_in_wait", 64'(mem_bus.mem_req_o), 64'd1);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("req_after_reset", 64'(mem_bus.mem_req_o), 64'd0);
        check("stall_in_reset", 64'(stall_o), 64'd0);
        check("read_data_after_reset", 64'(Read_Data_o), 64'd0);
        last_rd = '0;
        RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemRead_i = 1'b0;
        rst_i = 1'b1;
        nop();
        issue(1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 32'h0, 5'd21, 1);

`ifdef MEM_TIMEOUT_EN
        issue(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd8, 0);
        check("timeout_pulse", 64'(timeout_o), 64'd1);
        check("req_after_abort", 64'(mem_bus.mem_req_o), 64'd0);
        nop();
        check("timeout_one_cycle", 64'(timeout_o), 64'd0);
        issue(1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 5'd9, MAX_WAIT);
`endif

        repeat (3) nop();
        check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        check("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage RISC-V core. Converts the EX/MEM load/store control and data into a req/ack transaction on a variable-latency data memory port, and stalls the upstream pipeline until the access completes. Also acts as the MEM/WB pipeline register, presenting writeback control, ALU result, load data and destination register to the WB stage.

Parameters:
DATA_W, 32, width of address, write data and read data
MAX_WAIT, 15, WAIT-state cycle limit before abort; used only with MEM_TIMEOUT_EN

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
RegWrite_i  in  1  writeback enable from EX/MEM
MemtoReg_i  in  1  WB mux select from EX/MEM
MemRead_i  in  1  load request from EX/MEM
MemWrite_i  in  1  store request from EX/MEM
ALU_result_i  in  DATA_W  memory address or ALU result
Write_Data_i  in  DATA_W  store data
RD_addr_i  in  5  destination register
mem_req_o  out  1  memory request valid
mem_we_o  out  1  1 = write, 0 = read
mem_addr_o  out  DATA_W  word address, held stable while mem_req_o=1
mem_wdata_o  out  DATA_W  store data, held stable while mem_req_o=1
mem_ack_i  in  1  one-cycle completion strobe
mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i=1
stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
misalign_o  out  1  one-cycle pulse for a misaligned access
RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control
ALU_result_o, Read_Data_o  out  DATA_W each  MEM/WB data
RD_addr_o  out  5  MEM/WB destination

Behaviour:
- Access = MemRead_i | MemWrite_i. If both are set, the access is a write.
- Aligned means ALU_result_i[1:0] == 0.
- FSM states: IDLE, WAIT.
- IDLE, aligned access: stall_o=1 (combinational) this cycle. Latch address, data and we; next state WAIT.
- WAIT: mem_req_o=1 with address, data and we unchanged. stall_o = ~mem_ack_i.
- WAIT, mem_ack_i=1: at that edge, MEM/WB captures Read_Data_o=mem_rdata_i (loads), RegWrite_i/MemtoReg_i/ALU_result_i/RD_addr_i. Next state IDLE, mem_req_o=0 next cycle.
- Minimum cost of a memory op: 1 stall cycle plus 1 request cycle. Back-to-back accesses re-enter IDLE between transactions.
- mem_ack_i in IDLE is ignored.
- Non-memory op in IDLE: no stall; MEM/WB registers the inputs with 1-cycle latency; Read_Data_o holds its previous value.
- Any edge with stall_o=1: MEM/WB loads a bubble (RegWrite_o=0, MemtoReg_o=0; other fields don't-care/held). Each instruction therefore writes back exactly once.
- Misaligned access in IDLE: no request, no stall. Next cycle: misalign_o=1 for one cycle and MEM/WB bubble.
- Reset (rst_i=0 at an edge): state=IDLE. All outputs 0, including mem_req_o, stall_o (combinational term gated by rst_i), misalign_o and the MEM/WB fields. An in-flight request is dropped at the reset edge.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a 4-bit-minimum counter (clog2(MAX_WAIT+1)) clears on WAIT entry and increments each WAIT cycle without ack. When it reaches MAX_WAIT with no ack: abort to IDLE, drop mem_req_o, release stall, MEM/WB bubble, add output timeout_o (1-cycle pulse the cycle after abort). Ack on the limit cycle wins over abort.
- Undefined: WAIT persists until ack; timeout_o port absent.

Test Plan:
- Reset: rst_i=0 for 2 cycles with MemRead_i=1, ALU_result_i=0x40 -> mem_req_o=0, stall_o=0, all MEM/WB outputs 0; FSM IDLE after release.
- ALU op: RegWrite_i=1, ALU_result_i=0x1234, RD_addr_i=5 -> next cycle RegWrite_o=1, ALU_result_o=0x1234, RD_addr_o=5; stall_o never 1.
- Load, slow: MemRead_i=1 at 0x40, ack on 3rd WAIT cycle with rdata 0xDEADBEEF -> stall_o=1 for 3 cycles, mem_req_o=1 for 3 cycles with addr stable 0x40. Next cycle Read_Data_o=0xDEADBEEF, MemtoReg_o=1, RegWrite_o=1, exactly once.
- Store, zero-wait: MemWrite_i=1, addr 0x80, data 0xA5A5A5A5, ack in first WAIT cycle -> stall_o=1 for 1 cycle, mem_req_o=1 and mem_we_o=1 for 1 cycle, wdata 0xA5A5A5A5, RegWrite_o=0.
- Misaligned: MemRead_i=1, addr 0x42 -> mem_req_o stays 0, stall_o=0, misalign_o=1 for one cycle, RegWrite_o=0.
- Reset mid-WAIT, and timeout with MEM_TIMEOUT_EN and MAX_WAIT=4: rst_i=0 in WAIT -> mem_req_o=0 next cycle. No ack -> abort after 4 WAIT cycles, timeout_o pulse, stall_o released.
